// File: rtl/perceptron_learner_pkg.sv
// Shared definitions for the perceptron learner: FSM encoding, datapath widths
// and signed weight limits.
package perceptron_learner_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DECIDE, S_UPD} state_t;

  localparam int PAT_W   = 16;
  localparam int SCORE_W = 13;

  function automatic int w_max(input int bits);
    return (1 << (bits - 1)) - 1;
  endfunction

  function automatic int w_min(input int bits);
    return -(1 << (bits - 1));
  endfunction
endpackage

// File: rtl/perceptron_learner_sat_add.sv
// Signed saturating adder used to step one weight (or the bias) per UPD cycle.
module sat_add
  import perceptron_learner_pkg::*;
#(
  parameter int W_BITS = 8
) (
  input  logic signed [W_BITS-1:0] a,
  input  logic signed [W_BITS-1:0] b,
  output logic signed [W_BITS-1:0] sum
);
  localparam logic signed [W_BITS:0] MAXV = (W_BITS+1)'(w_max(W_BITS));
  localparam logic signed [W_BITS:0] MINV = (W_BITS+1)'(w_min(W_BITS));

  logic signed [W_BITS:0] full;
  assign full = {a[W_BITS-1], a} + {b[W_BITS-1], b};

  always_comb begin
    sum = full[W_BITS-1:0];
    if (full > MAXV)      sum = MAXV[W_BITS-1:0];
    else if (full < MINV) sum = MINV[W_BITS-1:0];
  end
endmodule

// File: rtl/perceptron_learner.sv
// Serial perceptron: 16-cycle accumulate, 1-cycle decide, 17-cycle update.
// Training and inference share the ACC/DECIDE path; only training enters UPD.
module perceptron_learner
  import perceptron_learner_pkg::*;
#(
  parameter int LR     = 1,
  parameter int W_BITS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PAT_W-1:0]          train_x,
  input  logic                      train_learn,
  input  logic                      train_is_O,
  input  logic [PAT_W-1:0]          infer_x,
  input  logic                      infer_start,
  output logic                      busy,
  output logic                      infer_done,
  output logic                      infer_is_O,
  output logic signed [SCORE_W-1:0] infer_score,
  output logic [15:0]               sample_count,
  output logic [15:0]               err_count
);
  localparam logic signed [W_BITS-1:0] STEP_P = W_BITS'(LR);
  localparam logic signed [W_BITS-1:0] STEP_N = W_BITS'(-LR);

  state_t state, state_nx;
  logic signed [W_BITS-1:0]  w [PAT_W];
  logic signed [W_BITS-1:0]  bias;
  logic signed [SCORE_W-1:0] acc, acc_term, bias_ext;
  logic [4:0]       idx;
  logic [3:0]       widx;
  logic [PAT_W-1:0] op_x, last_x;
  logic             op_lbl, op_train, last_lbl, learn_q, pending;
  logic             train_trig, infer_go, pred_o, train_err;
  logic signed [W_BITS-1:0] acc_w, upd_cur, upd_step, upd_sum;

  // A held train_learn with an unchanged pattern/label is the same sample.
  assign train_trig = (state == S_IDLE) && train_learn &&
                      (!learn_q || (train_x != last_x) || (train_is_O != last_lbl));
  assign infer_go   = (state == S_IDLE) && !train_trig && (infer_start || pending);
  assign pred_o     = !acc[SCORE_W-1];
  assign train_err  = op_train && (pred_o != op_lbl);
  assign busy       = (state != S_IDLE);

  assign bias_ext = {{(SCORE_W-W_BITS){bias[W_BITS-1]}}, bias};
  assign acc_w    = w[idx[3:0]];
  always_comb begin
    acc_term = '0;
    if (op_x[idx[3:0]]) acc_term = {{(SCORE_W-W_BITS){acc_w[W_BITS-1]}}, acc_w};
  end

  // UPD slot 0 is the bias, slots 1..16 map to w[0..15].
  assign widx     = idx[3:0] - 4'd1;
  assign upd_cur  = (idx == 5'd0) ? bias : w[widx];
  assign upd_step = op_lbl ? STEP_P : STEP_N;

  sat_add #(.W_BITS(W_BITS)) u_sat (
    .a   (upd_cur),
    .b   (upd_step),
    .sum (upd_sum)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (train_trig || infer_go) state_nx = S_ACC;
      S_ACC:    if (idx == 5'd15) state_nx = S_DECIDE;
      S_DECIDE: state_nx = train_err ? S_UPD : S_IDLE;
      S_UPD:    if (idx == 5'd16) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PAT_W; i++) w[i] <= '0;
      bias         <= '0;
      acc          <= '0;
      idx          <= '0;
      op_x         <= '0;
      op_lbl       <= 1'b0;
      op_train     <= 1'b0;
      last_x       <= '0;
      last_lbl     <= 1'b0;
      learn_q      <= 1'b0;
      pending      <= 1'b0;
      infer_done   <= 1'b0;
      infer_is_O   <= 1'b0;
      infer_score  <= '0;
      sample_count <= '0;
      err_count    <= '0;
    end else begin
      learn_q    <= train_learn;
      infer_done <= 1'b0;
      if (infer_start && (busy || train_trig)) pending <= 1'b1;
      case (state)
        S_IDLE: begin
          idx <= '0;
          acc <= bias_ext;
          if (train_trig) begin
            op_x     <= train_x;
            op_lbl   <= train_is_O;
            op_train <= 1'b1;
            last_x   <= train_x;
            last_lbl <= train_is_O;
          end else if (infer_go) begin
            op_x     <= infer_x;
            op_train <= 1'b0;
            pending  <= 1'b0;
          end
        end
        S_ACC: begin
          acc <= acc + acc_term;
          idx <= idx + 5'd1;
        end
        S_DECIDE: begin
          idx <= '0;
          if (op_train) begin
            if (sample_count != 16'hFFFF) sample_count <= sample_count + 16'd1;
            if (train_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          end else begin
            infer_done  <= 1'b1;
            infer_is_O  <= pred_o;
            infer_score <= acc;
          end
        end
        S_UPD: begin
          idx <= idx + 5'd1;
          if (idx == 5'd0)   bias    <= upd_sum;
          else if (op_x[widx]) w[widx] <= upd_sum;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_perceptron_learner.sv
// Directed bench: DUT 0 uses default LR=1; DUT 1 uses LR=64 to reach weight
// saturation in a handful of samples.
module tb_perceptron_learner;
  logic clk, rst;
  logic [15:0]        train_x [2];
  logic [15:0]        infer_x [2];
  logic               train_learn [2], train_is_O [2], infer_start [2];
  logic               busy [2], infer_done [2], infer_is_O [2];
  logic signed [12:0] infer_score [2];
  logic [15:0]        sample_count [2], err_count [2];

  int checks = 0;
  int failures = 0;

  perceptron_learner dut0 (
    .clk(clk), .rst(rst),
    .train_x(train_x[0]), .train_learn(train_learn[0]), .train_is_O(train_is_O[0]),
    .infer_x(infer_x[0]), .infer_start(infer_start[0]),
    .busy(busy[0]), .infer_done(infer_done[0]), .infer_is_O(infer_is_O[0]),
    .infer_score(infer_score[0]), .sample_count(sample_count[0]), .err_count(err_count[0])
  );

  perceptron_learner #(.LR(64), .W_BITS(8)) dut1 (
    .clk(clk), .rst(rst),
    .train_x(train_x[1]), .train_learn(train_learn[1]), .train_is_O(train_is_O[1]),
    .infer_x(infer_x[1]), .infer_start(infer_start[1]),
    .busy(busy[1]), .infer_done(infer_done[1]), .infer_is_O(infer_is_O[1]),
    .infer_score(infer_score[1]), .sample_count(sample_count[1]), .err_count(err_count[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [15:0] x; int score; logic is_o; } ivec_t;
  typedef struct { logic [15:0] x; logic lbl; } tvec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // lat = edges from the trigger edge until busy reads low again
  task automatic train(input int k, input logic [15:0] x, input logic lbl, output int lat);
    train_x[k] = x; train_is_O[k] = lbl; train_learn[k] = 1'b1;
    step();
    train_learn[k] = 1'b0;
    lat = 1;
    while (busy[k] && lat < 100) begin step(); lat++; end
  endtask

  task automatic infer(input int k, input logic [15:0] x, output int lat,
                       output int score, output logic is_o);
    infer_x[k] = x; infer_start[k] = 1'b1;
    step();
    infer_start[k] = 1'b0;
    lat = 1;
    while (!infer_done[k] && lat < 100) begin step(); lat++; end
    score = infer_score[k];
    is_o  = infer_is_O[k];
  endtask

  initial begin
    ivec_t itab [6];
    tvec_t stab [7];
    int lat, sc, fall, done_at;
    logic io;

    for (int k = 0; k < 2; k++) begin
      train_x[k] = '0; infer_x[k] = '0;
      train_learn[k] = 1'b0; train_is_O[k] = 1'b0; infer_start[k] = 1'b0;
    end
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();

    check("reset_busy",   busy[0], 0);
    check("reset_done",   infer_done[0], 0);
    check("reset_is_o",   infer_is_O[0], 0);
    check("reset_score",  infer_score[0], 0);
    check("reset_samples", sample_count[0], 0);
    check("reset_errs",   err_count[0], 0);

    // zero weights: any pattern scores 0 and classifies as O
    infer(0, 16'hFFFF, lat, sc, io);
    check("inf0_latency", lat, 18);
    check("inf0_score",   sc, 0);
    check("inf0_is_o",    io, 1);
    step();
    check("inf0_done_pulse", infer_done[0], 0);
    check("inf0_samples", sample_count[0], 0);

    train(0, 16'b1111100110011111, 1'b1, lat);
    check("train_o_latency", lat, 18);
    check("train_o_samples", sample_count[0], 1);
    check("train_o_errs",    err_count[0], 0);

    rst = 1'b1; step(); rst = 1'b0; step();

    train(0, 16'b1001011001101001, 1'b0, lat);
    check("train_x_latency", lat, 35);
    check("train_x_samples", sample_count[0], 1);
    check("train_x_errs",    err_count[0], 1);

    // b=-1, w{0,3,5,6,9,10,12,15}=-1
    itab[0] = '{16'h0000, -1, 1'b0};
    itab[1] = '{16'hFFFF, -9, 1'b0};
    itab[2] = '{16'h9669, -9, 1'b0};
    itab[3] = '{16'h6996, -1, 1'b0};
    itab[4] = '{16'h0001, -2, 1'b0};
    itab[5] = '{16'h0002, -1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      infer(0, itab[i].x, lat, sc, io);
      check($sformatf("tbl%0d_latency", i), lat, 18);
      check($sformatf("tbl%0d_score", i), sc, itab[i].score);
      check($sformatf("tbl%0d_is_o", i), io, itab[i].is_o);
    end
    check("tbl_samples", sample_count[0], 1);
    check("tbl_errs",    err_count[0], 1);

    // held learn: one sample per distinct pattern/label
    train_x[0] = 16'h0000; train_is_O[0] = 1'b1; train_learn[0] = 1'b1;
    for (int n = 0; n < 60; n++) step();
    check("held_samples", sample_count[0], 2);
    check("held_errs",    err_count[0], 2);
    train_x[0] = 16'h0001;
    for (int n = 0; n < 60; n++) step();
    train_learn[0] = 1'b0;
    check("held_change_samples", sample_count[0], 3);
    check("held_change_errs",    err_count[0], 3);
    // now b=1, w0=0

    // inference request during UPD runs from the first IDLE cycle
    train_x[0] = 16'h0000; train_is_O[0] = 1'b0; train_learn[0] = 1'b1;
    fall = 0; done_at = 0; sc = 99; io = 1'b0;
    for (int n = 1; n <= 70; n++) begin
      step();
      if (n == 1) train_learn[0] = 1'b0;
      if (n == 25) begin infer_x[0] = 16'h0008; infer_start[0] = 1'b1; end
      if (n == 26) begin infer_start[0] = 1'b0; infer_x[0] = 16'h0001; end
      if (!busy[0] && fall == 0) fall = n;
      if (infer_done[0] && done_at == 0) begin done_at = n; sc = infer_score[0]; io = infer_is_O[0]; end
    end
    check("pend_upd_busy",  fall, 35);
    check("pend_upd_done",  done_at, 53);
    check("pend_upd_score", sc, 0);
    check("pend_upd_is_o",  io, 1);
    check("pend_upd_samples", sample_count[0], 4);
    check("pend_upd_errs",    err_count[0], 4);

    // simultaneous trigger and request: training first
    train_x[0] = 16'h0002; train_is_O[0] = 1'b1; train_learn[0] = 1'b1;
    infer_x[0] = 16'h0008; infer_start[0] = 1'b1;
    fall = 0; done_at = 0; sc = 99; io = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      step();
      if (n == 1) begin train_learn[0] = 1'b0; infer_start[0] = 1'b0; infer_x[0] = 16'hFFFF; end
      if (!busy[0] && fall == 0) fall = n;
      if (infer_done[0] && done_at == 0) begin done_at = n; sc = infer_score[0]; io = infer_is_O[0]; end
    end
    check("simul_busy",  fall, 18);
    check("simul_done",  done_at, 36);
    check("simul_score", sc, -7);
    check("simul_is_o",  io, 0);
    check("simul_samples", sample_count[0], 5);
    check("simul_errs",    err_count[0], 4);

    // LR=64: drive w0 to the negative limit, then push past it
    stab[0] = '{16'h0001, 1'b0};
    stab[1] = '{16'h0002, 1'b1};
    stab[2] = '{16'h0003, 1'b0};
    stab[3] = '{16'h0002, 1'b1};
    stab[4] = '{16'h0008, 1'b0};
    stab[5] = '{16'h0004, 1'b1};
    stab[6] = '{16'h0007, 1'b0};
    for (int i = 0; i < 7; i++) begin
      train(1, stab[i].x, stab[i].lbl, lat);
      check($sformatf("sat%0d_latency", i), lat, 35);
    end
    check("sat_errs", err_count[1], 7);
    infer(1, 16'h0001, lat, sc, io);
    check("sat_w0_score", sc, -192);
    infer(1, 16'h0008, lat, sc, io);
    check("sat_w3_score", sc, -128);
    infer(1, 16'h0000, lat, sc, io);
    check("sat_bias_score", sc, -64);

    // reset in the 10th UPD cycle abandons the partial update
    train_x[0] = 16'h0000; train_is_O[0] = 1'b0; train_learn[0] = 1'b1;
    for (int n = 1; n <= 27; n++) begin
      step();
      if (n == 1) train_learn[0] = 1'b0;
    end
    check("pre_rst_busy", busy[0], 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_busy",    busy[0], 0);
    check("rst_async_score",   infer_score[0], 0);
    check("rst_async_samples", sample_count[0], 0);
    check("rst_async_errs",    err_count[0], 0);
    step();
    check("rst_next_done", infer_done[0], 0);
    check("rst_next_is_o", infer_is_O[0], 0);
    rst = 1'b0;
    step();
    infer(0, 16'hFFFF, lat, sc, io);
    check("post_rst_latency", lat, 18);
    check("post_rst_score",   sc, 0);
    check("post_rst_is_o",    io, 1);
    check("post_rst_samples", sample_count[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
